// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the instruction ROM address, realigns 1-cycle ROM data through a
// 1-entry skid buffer onto a valid/ready output, handles branch redirect and END halt.
module instr_fetch_unit #(
  parameter int          AW     = 8,
  parameter int          DW     = 16,
  parameter logic [3:0]  END_OP = 4'b1111
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] iram_addr,
  input  logic [DW-1:0] iram_q,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_addr,
  output logic          halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, skid_pc_q, skid_pc_d, out_pc_q, out_pc_d;
  logic [DW-1:0] skid_data_q, skid_data_d, out_data_q, out_data_d;
  logic          pend_q, pend_d, skid_vld_q, skid_vld_d, out_vld_q, out_vld_d;
  logic          halted_q, halted_d;
  logic          run, accept, out_free, halt_now, issue;

  always_comb begin
    run      = (state_q == RUN);
    accept   = out_vld_q && instr_ready;
    out_free = !out_vld_q || instr_ready;
    halt_now = run && accept && !redirect_en && (out_data_q[DW-1 -: 4] == END_OP);
    issue    = run && !skid_vld_q && out_free && !halt_now && !redirect_en;

    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    halted_d    = halted_q;

    if (run && redirect_en) begin
      // Everything already requested or buffered is wrong-path.
      pc_d       = redirect_addr;
      pend_d     = 1'b0;
      skid_vld_d = 1'b0;
      out_vld_d  = 1'b0;
    end else if (halt_now) begin
      state_d    = HALTED;
      halted_d   = 1'b1;
      pend_d     = 1'b0;
      skid_vld_d = 1'b0;
      out_vld_d  = 1'b0;
    end else if (run) begin
      pend_d    = issue;
      pend_pc_d = pc_q;
      if (issue) pc_d = pc_q + 1'b1;
      if (out_free) begin
        // Skid holds the older word, so it drains before the ROM response.
        if (skid_vld_q) begin
          out_vld_d  = 1'b1;
          out_data_d = skid_data_q;
          out_pc_d   = skid_pc_q;
          skid_vld_d = 1'b0;
        end else if (pend_q) begin
          out_vld_d  = 1'b1;
          out_data_d = iram_q;
          out_pc_d   = pend_pc_q;
        end else begin
          out_vld_d  = 1'b0;
        end
      end else if (pend_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = iram_q;
        skid_pc_d   = pend_pc_q;
      end
    end else if (start) begin
      state_d    = RUN;
      pc_d       = '0;
      halted_d   = 1'b0;
      pend_d     = 1'b0;
      skid_vld_d = 1'b0;
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      pend_q     <= 1'b0;
      skid_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_pc_q   <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      skid_vld_q <= skid_vld_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_pc_q   <= out_pc_d;
      halted_q   <= halted_d;
    end
  end

  // Payload-only registers; their valid flags above qualify them.
  always_ff @(posedge clock) begin
    pend_pc_q   <= pend_pc_d;
    skid_data_q <= skid_data_d;
    skid_pc_q   <= skid_pc_d;
  end

  assign iram_addr   = pc_q;
  assign instr       = out_data_q;
  assign instr_pc    = out_pc_q;
  assign instr_valid = out_vld_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model, stream-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  iram_addr;
  logic [15:0] iram_q = '0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect_en = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic        halted;

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.AW(8), .DW(16), .END_OP(4'b1111)) dut (
    .clock(clock), .reset(reset), .start(start), .iram_addr(iram_addr), .iram_q(iram_q),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .halted(halted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) iram_q <= rom[iram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: the accepted stream is ROM[exp_pc], exp_pc counting up from 0 after
  // start (or from redirect_addr after a redirect), modulo 256; END accepted halts.
  logic        m_run = 1'b0;
  logic        m_halted = 1'b0;
  logic [7:0]  exp_pc = '0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_instr = '0;
  logic [7:0]  prev_pc = '0;
  logic [15:0] exp_word;

  always @(negedge clock) begin
    if (reset) begin
      m_run = 1'b0;
      m_halted = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("m_halted", {31'b0, halted}, {31'b0, m_halted});
      if (!m_run) chk("m_idle_valid", {31'b0, instr_valid}, 32'd0);
      if (stall_prev) begin
        chk("m_hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("m_hold_instr", {16'b0, instr}, {16'b0, prev_instr});
        chk("m_hold_pc", {24'b0, instr_pc}, {24'b0, prev_pc});
      end
      if (m_run && redirect_en) begin
        exp_pc = redirect_addr;
      end else if (instr_valid && instr_ready) begin
        exp_word = rom[exp_pc];
        chk("m_instr", {16'b0, instr}, {16'b0, exp_word});
        chk("m_pc", {24'b0, instr_pc}, {24'b0, exp_pc});
        if (exp_word[15:12] == 4'hF) begin
          m_run = 1'b0;
          m_halted = 1'b1;
        end
        exp_pc = exp_pc + 8'd1;
      end
      stall_prev = instr_valid && !instr_ready && !redirect_en;
      prev_instr = instr;
      prev_pc    = instr_pc;
      if (start && !m_run) begin
        m_run = 1'b1;
        m_halted = 1'b0;
        exp_pc = '0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {4'(1 + i % 14), 4'h0, 8'(i)};
    rom[0] = 16'hA0A0;
    rom[1] = 16'hB0B1;
    rom[2] = 16'hC0C2;
    rom[3] = 16'hD0D3;

    step(); step();
    reset = 1'b0;
    step();
    chk("rst_addr", {24'b0, iram_addr}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", {16'b0, instr}, 32'h0);
    chk("rst_pc", {24'b0, instr_pc}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);

    // 1: latency and back-to-back stream
    do_start();
    chk("t1_addr_e0", {24'b0, iram_addr}, 32'h0);
    chk("t1_valid_e0", {31'b0, instr_valid}, 32'h0);
    step();
    chk("t1_valid_e1", {31'b0, instr_valid}, 32'h0);
    chk("t1_addr_e1", {24'b0, iram_addr}, 32'h1);
    step();
    chk("t1_valid_e2", {31'b0, instr_valid}, 32'h1);
    chk("t1_instr_a", {16'b0, instr}, 32'hA0A0);
    chk("t1_pc_a", {24'b0, instr_pc}, 32'h0);
    step();
    chk("t1_instr_b", {16'b0, instr}, 32'hB0B1);
    chk("t1_pc_b", {24'b0, instr_pc}, 32'h1);
    step();
    chk("t1_instr_c", {16'b0, instr}, 32'hC0C2);
    step();
    chk("t1_instr_d", {16'b0, instr}, 32'hD0D3);
    chk("t1_pc_d", {24'b0, instr_pc}, 32'h3);

    // 2: 4-cycle backpressure
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_frozen_pc", {24'b0, instr_pc}, 32'h3);
      chk("t2_frozen_addr", {24'b0, iram_addr}, 32'h5);
    end
    instr_ready = 1'b1;
    step();
    chk("t2_skid_out_valid", {31'b0, instr_valid}, 32'h1);
    chk("t2_skid_out_pc", {24'b0, instr_pc}, 32'h4);
    for (int i = 0; i < 4; i++) step();

    // 3: redirect with words queued in output and skid
    instr_ready = 1'b0;
    step(); step();
    redirect_en = 1'b1;
    redirect_addr = 8'h23;
    step();
    redirect_en = 1'b0;
    instr_ready = 1'b1;
    chk("t3_valid_r0", {31'b0, instr_valid}, 32'h0);
    chk("t3_addr_r0", {24'b0, iram_addr}, 32'h23);
    step();
    chk("t3_valid_r1", {31'b0, instr_valid}, 32'h0);
    step();
    chk("t3_valid_r2", {31'b0, instr_valid}, 32'h1);
    chk("t3_pc_r2", {24'b0, instr_pc}, 32'h23);
    chk("t3_instr_r2", {16'b0, instr}, 32'h8023);
    for (int i = 0; i < 3; i++) step();

    // 5: wraparound, then 4: halt on END at address 5
    redirect_en = 1'b1;
    redirect_addr = 8'hFE;
    step();
    redirect_en = 1'b0;
    step();
    chk("t5_valid_r1", {31'b0, instr_valid}, 32'h0);
    step();
    chk("t5_pc_fe", {24'b0, instr_pc}, 32'hFE);
    step();
    chk("t5_pc_ff", {24'b0, instr_pc}, 32'hFF);
    step();
    chk("t5_pc_00", {24'b0, instr_pc}, 32'h00);
    step();
    chk("t5_pc_01", {24'b0, instr_pc}, 32'h01);
    chk("t5_valid_01", {31'b0, instr_valid}, 32'h1);
    rom[5] = 16'hF000;
    step(); step(); step(); step();
    chk("t4_pc_end", {24'b0, instr_pc}, 32'h05);
    chk("t4_instr_end", {16'b0, instr}, 32'hF000);
    step();
    chk("t4_halted", {31'b0, halted}, 32'h1);
    chk("t4_valid_off", {31'b0, instr_valid}, 32'h0);
    chk("t4_addr_frozen", {24'b0, iram_addr}, 32'h07);
    step(); step();
    chk("t4_still_halted", {31'b0, halted}, 32'h1);
    chk("t4_addr_still", {24'b0, iram_addr}, 32'h07);
    rom[5] = 16'h6005;
    do_start();
    chk("t4_restart_halted", {31'b0, halted}, 32'h0);
    chk("t4_restart_addr", {24'b0, iram_addr}, 32'h0);
    step(); step();
    chk("t4_refetch_valid", {31'b0, instr_valid}, 32'h1);
    chk("t4_refetch_instr", {16'b0, instr}, 32'hA0A0);
    for (int i = 0; i < 3; i++) step();

    // 6: async reset with output valid and skid full
    instr_ready = 1'b0;
    step(); step();
    chk("t6_pre_valid", {31'b0, instr_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("t6_rst_instr", {16'b0, instr}, 32'h0);
    chk("t6_rst_pc", {24'b0, instr_pc}, 32'h0);
    chk("t6_rst_addr", {24'b0, iram_addr}, 32'h0);
    chk("t6_rst_halted", {31'b0, halted}, 32'h0);
    step();
    reset = 1'b0;
    instr_ready = 1'b1;
    step();
    do_start();
    chk("t6_valid_e0", {31'b0, instr_valid}, 32'h0);
    step();
    chk("t6_valid_e1", {31'b0, instr_valid}, 32'h0);
    step();
    chk("t6_valid_e2", {31'b0, instr_valid}, 32'h1);
    chk("t6_instr_e2", {16'b0, instr}, 32'hA0A0);
    chk("t6_pc_e2", {24'b0, instr_pc}, 32'h0);
    for (int i = 0; i < 6; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
